// File: rtl/multi_byte_add_ctrl_pkg.sv
// Shared types, default sizing and flag helpers for the multi-byte add controller.
package multi_byte_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_BYTES  = 4;
  localparam int unsigned DEF_TIMEOUT    = 15;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/multi_byte_add_timer.sv
// Loadable down-counter; last_o flags that the next decrement reaches zero.
module multi_byte_add_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load has priority over decrement; the counter saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// Sequences a wide add/subtract as LSB-first byte operations on an external byte adder.
module multi_byte_add_ctrl
  import multi_byte_add_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_BYTES  = DEF_NUM_BYTES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [DATA_WIDTH*NUM_BYTES-1:0] req_a,
  input  logic [DATA_WIDTH*NUM_BYTES-1:0] req_b,
  input  logic                            req_cin,
  input  logic                            req_sub,
  output logic                            byte_start,
  output logic [DATA_WIDTH-1:0]           byte_a,
  output logic [DATA_WIDTH-1:0]           byte_b,
  output logic                            byte_cin,
  input  logic [DATA_WIDTH-1:0]           byte_sum,
  input  logic                            byte_cout,
  input  logic                            byte_done,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH*NUM_BYTES-1:0] res_sum,
  output logic                            res_cout,
  output logic                            res_ovf,
  output logic                            res_err
);

  localparam int unsigned W    = DATA_WIDTH * NUM_BYTES;
  localparam int unsigned IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;       // already inverted for subtract
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;
  logic            timer_load, timer_dec, timer_last;
  logic            busy, take;

  // Byte views of the latched operands so the current byte is a plain array select.
  logic [DATA_WIDTH-1:0] a_bytes [NUM_BYTES];
  logic [DATA_WIDTH-1:0] b_bytes [NUM_BYTES];

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign a_bytes[gi] = a_q[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_bytes[gi] = b_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  multi_byte_add_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .dec_i      (timer_dec),
    .load_val_i (TW'(TIMEOUT)),
    .last_o     (timer_last)
  );

  assign busy = (state_q == ISSUE) || (state_q == WAIT);
  // A done is only meaningful while a byte operation is outstanding.
  assign take = busy && byte_done;

  // Next-state logic: request latch, byte sequencing, timeout and result capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    byte_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_sub ? ~req_b : req_b;
          carry_d = req_sub ? 1'b1 : req_cin;
          idx_d   = '0;
          res_d   = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        byte_start = 1'b1;
        timer_load = 1'b1;
        if (!byte_done) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!byte_done) begin
          timer_dec = 1'b1;
          if (timer_last) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte capture is shared by ISSUE (combinational responder) and WAIT.
    if (take) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (idx_q == IDXW'(i)) begin
          res_d[i*DATA_WIDTH +: DATA_WIDTH] = byte_sum;
        end
      end
      carry_d = byte_cout;
      if (idx_q == LAST_IDX) begin
        state_d = RESP;
      end else begin
        idx_d   = idx_q + IDXW'(1);
        state_d = ISSUE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign byte_a    = busy ? a_bytes[idx_q] : '0;
  assign byte_b    = busy ? b_bytes[idx_q] : '0;
  assign byte_cin  = busy && carry_q;
  assign res_valid = (state_q == RESP);
  assign res_sum   = res_q;
  assign res_err   = res_valid && err_q;
  assign res_cout  = res_valid && !err_q && carry_q;
  assign res_ovf   = res_valid && !err_q && signed_ovf(a_q[W-1], b_q[W-1], res_q[W-1]);

endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
module tb_multi_byte_add_ctrl;

  localparam int DW = 8;
  localparam int NB = 4;
  localparam int W  = DW * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          req_cin = 1'b0;
  logic          req_sub = 1'b0;
  logic          byte_start;
  logic [DW-1:0] byte_a, byte_b;
  logic          byte_cin;
  logic [DW-1:0] resp_sum = '0;
  logic          resp_cout = 1'b0;
  logic          resp_done = 1'b0;
  logic          inj_done = 1'b0;
  logic          byte_done;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_sum;
  logic          res_cout, res_ovf, res_err;

  assign byte_done = resp_done | inj_done;

  always #5 clk = ~clk;

  multi_byte_add_ctrl #(.DATA_WIDTH(DW), .NUM_BYTES(NB), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .byte_start(byte_start), .byte_a(byte_a), .byte_b(byte_b), .byte_cin(byte_cin),
    .byte_sum(resp_sum), .byte_cout(resp_cout), .byte_done(byte_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_err(res_err)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf, last_err;

  // Responder: mode 0 answers in the start cycle, mode 1 one cycle later.
  int   resp_mode = 1;
  int   drop_idx = -1;
  int   start_cnt = 0;
  logic pend = 1'b0;
  logic cin_log [256];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      resp_done = 1'b0;
    end else begin
      if (resp_mode == 0) begin
        resp_done = byte_start && (start_cnt != drop_idx);
      end else begin
        resp_done = pend;
        pend = byte_start && (start_cnt != drop_idx);
      end
      {resp_cout, resp_sum} = 9'(byte_a) + 9'(byte_b) + 9'(byte_cin);
      if (byte_start) begin
        if (start_cnt < 256) cin_log[start_cnt] = byte_cin;
        start_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int good);
    logic [W-1:0] bp;
    logic [W:0]   full;
    exp_t         e;
    bp = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.err = (good < NB);
    if (e.err) begin
      e.sum = '0;
      for (int i = 0; i < good; i++) e.sum[i*DW +: DW] = full[i*DW +: DW];
      e.cout = 1'b0;
      e.ovf  = 1'b0;
    end else begin
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == bp[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input int good);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_before_send", req_ready, 1);
    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    sb_q.push_back(model(a, b, cin, sub, good));
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
    req_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input int max_cyc, input int exp_lat,
                         input int hold, input bit late_done);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!res_valid && n < max_cyc) begin
      @(negedge clk); n++;
    end
    check({tag, "_valid"}, res_valid, 1);
    if (exp_lat > 0) check({tag, "_latency"}, cyc - acc_cyc, exp_lat);
    check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (late_done) begin
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check({tag, "_late_done_sum"}, res_sum, e.sum);
        check({tag, "_late_done_valid"}, res_valid, 1);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, res_valid, 1);
        check({tag, "_hold_sum"}, res_sum, e.sum);
        check({tag, "_hold_req_ready"}, req_ready, 0);
      end
      check({tag, "_sum"}, res_sum, e.sum);
      check({tag, "_cout"}, res_cout, e.cout);
      check({tag, "_ovf"}, res_ovf, e.ovf);
      check({tag, "_err"}, res_err, e.err);
      last_sum = res_sum; last_cout = res_cout; last_ovf = res_ovf; last_err = res_err;
      $display("txn %s sum=0x%08h cout=%0d ovf=%0d err=%0d lat=%0d", tag, res_sum,
               res_cout, res_ovf, res_err, cyc - acc_cyc);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_released"}, res_valid, 0);
    check({tag, "_back_idle"}, req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_byte_start"}, byte_start, 0);
    check({tag, "_byte_a"}, byte_a, 0);
    check({tag, "_byte_b"}, byte_b, 0);
    check({tag, "_byte_cin"}, byte_cin, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_sum"}, res_sum, 0);
    check({tag, "_res_flags"}, {res_cout, res_ovf, res_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         n;
    logic [3:0] exp_cin;

    // Reset state
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1-cycle responder, carry ripple into byte 1
    resp_mode = 1;
    base = start_cnt;
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, NB);
    receive("add_ripple", 40, 9, 0, 0);
    check("add_ripple_const", last_sum, 32'h00000100);
    check("add_ripple_starts", start_cnt - base, 4);
    exp_cin = 4'b0010;
    for (int i = 0; i < 4; i++) check("add_ripple_cin_seq", cin_log[base+i], exp_cin[i]);

    // Combinational responder, subtract with borrow
    resp_mode = 0;
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, NB);
    receive("sub_borrow", 40, 5, 0, 0);
    check("sub_borrow_const", {last_sum, last_cout, last_ovf}, {32'hFFFFFFFE, 1'b0, 1'b0});

    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, NB);
    receive("add_ovf", 40, 5, 0, 0);
    check("add_ovf_const", {last_sum, last_cout, last_ovf}, {32'h80000000, 1'b0, 1'b1});

    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, NB);
    receive("add_cin_wrap", 40, 5, 0, 0);
    check("add_cin_wrap_const", {last_sum, last_cout, last_ovf}, {32'h00000000, 1'b1, 1'b0});

    // Timeout on byte 2, then a late done in RESP
    resp_mode = 1;
    drop_idx = start_cnt + 2;
    send(32'h11223344, 32'h01020304, 1'b0, 1'b0, 2);
    receive("timeout", 60, 21, 0, 1);
    check("timeout_partial_const", {last_sum, last_err}, {32'h00003648, 1'b1});
    drop_idx = -1;

    // Backpressure on the result
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0, NB);
    receive("hold", 40, 9, 10, 0);

    // Stray done in IDLE
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    check("idle_done_req_ready", req_ready, 1);
    check("idle_done_byte_start", byte_start, 0);
    check("idle_done_res_valid", res_valid, 0);
    send(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b1, NB);
    receive("after_idle_done", 40, 9, 0, 0);

    // Reset during WAIT of byte 1
    drop_idx = start_cnt + 1;
    base = start_cnt;
    send(32'h01020304, 32'h05060708, 1'b0, 1'b0, NB);
    n = 0;
    while (start_cnt < base + 2 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("rst_mid_reached_byte1", start_cnt >= base + 2, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    sb_q.delete();
    drop_idx = -1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_idle", req_ready, 1);
    send(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, NB);
    receive("after_reset", 40, 9, 0, 0);

    // A few random operations with the combinational responder
    resp_mode = 0;
    for (int k = 0; k < 4; k++) begin
      send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), NB);
      receive("random", 40, 5, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_byte_add_ctrl.md
Name: multi_byte_add_ctrl

Overview:
- Initiator for the byte-level start/done add interface.
- Accepts one wide add or subtract request, then issues NUM_BYTES sequential byte operations to an external byte adder, LSB byte first.
- Chains the carry from each byte into the next, assembles the wide result, and returns it with carry, signed-overflow and timeout-error flags.
- Sits between the datapath control and the byte adder responder.

Parameters:
- DATA_WIDTH, 8: bits per byte operation.
- NUM_BYTES, 4: byte operations per request (at least 1).
- TIMEOUT, 15: maximum cycles spent in WAIT for one byte_done (at least 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block is idle and can accept a request.
- req_a  in  DATA_WIDTH*NUM_BYTES  operand A.
- req_b  in  DATA_WIDTH*NUM_BYTES  operand B.
- req_cin  in  1  carry in (add mode only).
- req_sub  in  1  1 selects A-B, computed as A + ~B + 1.
- byte_start  out  1  one-cycle strobe to the byte adder.
- byte_a  out  DATA_WIDTH  current byte of A.
- byte_b  out  DATA_WIDTH  current byte of B, inverted in sub mode.
- byte_cin  out  1  current chained carry.
- byte_sum  in  DATA_WIDTH  byte adder sum.
- byte_cout  in  1  byte adder carry out.
- byte_done  in  1  byte adder completion.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  DATA_WIDTH*NUM_BYTES  assembled result.
- res_cout  out  1  final carry; in sub mode, 1 means no borrow.
- res_ovf  out  1  signed overflow.
- res_err  out  1  timeout occurred; res_sum is partial.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE; the byte index, timeout counter and carry register are 0.
  - req_ready=1 and all other outputs are 0, including res_sum.
- IDLE: req_ready=1. When req_valid is high, latch A, B (inverted if req_sub), cin (req_sub ? 1 : req_cin) and the sub flag; clear idx; go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle with byte_start=1.
  - byte_a/byte_b are byte idx of the latched operands; byte_cin is the carry register.
  - Reload the timeout counter.
  - If byte_done=1 in this same cycle, capture immediately (see WAIT). Otherwise go to WAIT.
- WAIT:
  - byte_start=0.
  - byte_a, byte_b and byte_cin hold stable until byte_done.
  - On byte_done=1: write byte_sum into result byte idx and load byte_cout into the carry register.
    - If idx == NUM_BYTES-1, go to RESP.
    - Otherwise increment idx and go to ISSUE.
  - The timeout counter decrements each cycle without done. If it reaches 0, go to RESP with err=1, leaving unfilled result bytes 0.
- RESP:
  - res_valid=1; outputs stay stable until res_ready=1, then go to IDLE.
  - Flags: res_cout = final carry; res_ovf = (A_msb == B'_msb) && (sum_msb != A_msb), using the inverted B in sub mode; both are 0 when err=1.
- Throughput and latency:
  - One request in flight at a time; req_ready=0 outside IDLE.
  - Minimum latency from accept to res_valid is NUM_BYTES+1 cycles, when done is combinational in the ISSUE cycle.
- Boundary conditions:
  - A byte_done arriving in IDLE or RESP is ignored. A done that arrives the cycle after a timeout is also ignored.
  - A res_ready received while res_valid=0 has no effect.
  - req_valid and req_ready must not complete a handshake in the same cycle as a result handshake, because IDLE and RESP are distinct states.
  - Reset asserted mid-operation aborts immediately: no result is produced and outputs take their reset values.
  - With NUM_BYTES=1: IDLE, then ISSUE, then (WAIT), then RESP.

Decomposition:
- Shared package:
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - Default constants for DATA_WIDTH, NUM_BYTES and TIMEOUT.
  - Function for signed-overflow detection.
- Sub-module multi_byte_add_timer: loadable down-counter with an expiry flag, used for the timeout.
- The FSM, byte mux and result assembly stay in the top module.

Test Plan:
- Responder returns done 1 cycle after start. Add 0x000000FF + 0x00000001, cin=0 -> res_sum=0x00000100, cout=0, ovf=0; exactly 4 start pulses with byte_cin sequence 0,1,0,0.
- Combinational done (same cycle as start). Sub 0x00000005 - 0x00000007 -> res_sum=0xFFFFFFFE, cout=0 (borrow), ovf=0; res_valid 5 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001 -> res_sum=0x80000000, ovf=1, cout=0. Add 0xFFFFFFFF + 0x00000000 with cin=1 -> res_sum=0, cout=1, ovf=0.
- Responder never answers byte 2 -> res_valid after 15 WAIT cycles, err=1, res_sum bytes 2 and 3 = 0. A late done is then ignored.
- res_ready held low for 10 cycles -> res_* stable and req_ready=0 throughout. Accept, then start a second request; byte_done pulsed in IDLE -> no state change.
- rst_n pulsed low during WAIT of byte 1 -> outputs go to reset values immediately. The next request completes normally.
